// File: rtl/draw_sched_pkg.sv
// Shared types and default geometry for the draw scheduler and the
// wall/player controllers that feed it.
package draw_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LATCH = 2'b01,
    ST_DRAW  = 2'b11,
    ST_DONE  = 2'b10
  } draw_state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_BOX_W = 8;
  localparam int DEF_BOX_H = 8;
  localparam int DEF_X_W   = 8;
  localparam int DEF_Y_W   = 7;
  localparam int DEF_C_W   = 3;

endpackage

// File: rtl/draw_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping modulo N_REQ.
module draw_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int               j;
  logic [PTR_W-1:0] jj;

  // Scan farthest offset first so the nearest requester at or after ptr wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    j    = 0;
    jj   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = PTR_W'(j);
      if (req[jj]) begin
        pick     = '0;
        pick[jj] = 1'b1;
        idx      = jj;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates the single VGA write port among box-drawing requesters and
// sweeps one fixed-size box per grant, one pixel per cycle.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int BOX_W = DEF_BOX_W,
  parameter int BOX_H = DEF_BOX_H,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int C_W   = DEF_C_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*X_W-1:0] req_x,
  input  logic [N_REQ*Y_W-1:0] req_y,
  input  logic [N_REQ*C_W-1:0] req_colour,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CX_W  = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int CY_W  = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam logic [CX_W-1:0]  CX_LAST  = CX_W'(BOX_W - 1);
  localparam logic [CY_W-1:0]  CY_LAST  = CY_W'(BOX_H - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  draw_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [X_W-1:0]   base_x_q, base_x_d;
  logic [Y_W-1:0]   base_y_q, base_y_d;
  logic [C_W-1:0]   colour_q, colour_d;
  logic [CX_W-1:0]  cx_q, cx_d;
  logic [CY_W-1:0]  cy_q, cy_d;

  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

  draw_rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .pick(pick),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    colour_d = colour_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d   = pick_idx;
          grant_d = pick;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // Requester fields are sampled only here; later changes are ignored.
        base_x_d = req_x[win_q*X_W +: X_W];
        base_y_d = req_y[win_q*Y_W +: Y_W];
        colour_d = req_colour[win_q*C_W +: C_W];
        cx_d     = '0;
        cy_d     = '0;
        state_d  = ST_DRAW;
      end
      ST_DRAW: begin
        if (cx_q == CX_LAST) begin
          cx_d = '0;
          if (cy_q == CY_LAST) state_d = ST_DONE;
          else                 cy_d    = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      grant_q  <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      colour_q <= colour_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
    end
  end

  // Outputs decode registered state only; coordinates wrap at the screen edge.
  assign grant      = grant_q;
  assign done       = (state_q == ST_DONE) ? grant_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign vga_plot   = (state_q == ST_DRAW);
  assign vga_x      = base_x_q + X_W'(cx_q);
  assign vga_y      = base_y_q + Y_W'(cy_q);
  assign vga_colour = colour_q;

endmodule
